// File: rtl/output_stream_loader_if.sv
// Handshake and data bundle between the watchdog result registers and the nibble output loader.
// master drives requests and sink readiness; slave is the loader itself.
interface output_stream_loader_if #(
  parameter int unsigned W      = 32,
  parameter int unsigned NWORDS = 2,
  parameter int unsigned MODE_W = 3
);
  logic                  start;
  logic [MODE_W-1:0]     mode;
  logic                  abort;
  logic [NWORDS*W-1:0]   words;
  logic                  out_ready;
  logic                  out_valid;
  logic [MODE_W+4:0]     out_byte;
  logic                  busy;
  logic                  done;

  modport master (
    output start, mode, abort, words, out_ready,
    input  out_valid, out_byte, busy, done
  );

  modport slave (
    input  start, mode, abort, words, out_ready,
    output out_valid, out_byte, busy, done
  );
endinterface

// File: rtl/output_stream_loader.sv
// Serialises an NWORDS x W frame as {mode, valid, nibble} bytes with ready/valid, abort and done.
// Define OUTPUT_STREAM_CSUM_EN to append an XOR-of-nibbles trailer symbol to every frame.
module output_stream_loader #(
  parameter int unsigned W      = 32,
  parameter int unsigned NWORDS = 2,
  parameter int unsigned MODE_W = 3
) (
  input logic                   clk,
  input logic                   rst,
  output_stream_loader_if.slave bus
);
  localparam int unsigned NIB = W / 4;
  localparam int unsigned NIW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned WIW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef OUTPUT_STREAM_CSUM_EN
  typedef enum logic [1:0] {StIdle, StSend, StCsum} state_e;
`else
  typedef enum logic [0:0] {StIdle, StSend} state_e;
`endif

  state_e                state_q, state_d;
  logic [WIW-1:0]        word_idx_q, word_idx_d;
  logic [NIW-1:0]        nib_idx_q, nib_idx_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [NWORDS*W-1:0]   data_q, data_d;
  logic                  done_q, done_d;
  logic [3:0]            nibble;
  logic                  xfer;
`ifdef OUTPUT_STREAM_CSUM_EN
  logic [3:0]            csum_q, csum_d;
`endif

  always_comb begin
    nibble = data_q[int'(word_idx_q) * int'(W) + int'(nib_idx_q) * 4 +: 4];
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_byte  = '0;
    case (state_q)
      StSend: begin
        bus.out_valid = 1'b1;
        bus.out_byte  = {mode_q, 1'b1, nibble};
      end
`ifdef OUTPUT_STREAM_CSUM_EN
      StCsum: begin
        bus.out_valid = 1'b1;
        bus.out_byte  = {mode_q, 1'b1, csum_q};
      end
`endif
      default: ;
    endcase
  end

  assign xfer     = bus.out_valid && bus.out_ready;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    nib_idx_d  = nib_idx_q;
    mode_d     = mode_q;
    data_d     = data_q;
    done_d     = 1'b0;
`ifdef OUTPUT_STREAM_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StSend;
          mode_d     = bus.mode;
          data_d     = bus.words;
          word_idx_d = '0;
          nib_idx_d  = NIW'(NIB - 1);
`ifdef OUTPUT_STREAM_CSUM_EN
          csum_d     = '0;
`endif
        end
      end
      StSend: begin
        if (xfer) begin
`ifdef OUTPUT_STREAM_CSUM_EN
          csum_d = csum_q ^ nibble;
`endif
          if (nib_idx_q != '0) begin
            nib_idx_d = nib_idx_q - 1'b1;
          end else if (word_idx_q != WIW'(NWORDS - 1)) begin
            word_idx_d = word_idx_q + 1'b1;
            nib_idx_d  = NIW'(NIB - 1);
          end else begin
`ifdef OUTPUT_STREAM_CSUM_EN
            state_d = StCsum;
`else
            state_d = StIdle;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef OUTPUT_STREAM_CSUM_EN
      StCsum: begin
        if (xfer) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // Abort wins over start and over a transfer in the same cycle.
    if (bus.abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      nib_idx_q  <= '0;
      mode_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
`ifdef OUTPUT_STREAM_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      nib_idx_q  <= nib_idx_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      done_q     <= done_d;
`ifdef OUTPUT_STREAM_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_output_stream_loader.sv
// Directed bench for output_stream_loader with a byte scoreboard; honours OUTPUT_STREAM_CSUM_EN.
module tb_output_stream_loader;
  localparam int unsigned W      = 32;
  localparam int unsigned NWORDS = 2;
  localparam int unsigned MODE_W = 3;
  localparam logic [2:0]  MODE   = 3'b101;
`ifdef OUTPUT_STREAM_CSUM_EN
  localparam int L = 17;
`else
  localparam int L = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc;
  logic [7:0] exp_q[$];

  output_stream_loader_if #(.W(W), .NWORDS(NWORDS), .MODE_W(MODE_W)) bus ();

  output_stream_loader #(.W(W), .NWORDS(NWORDS), .MODE_W(MODE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sym(input logic [3:0] n);
    return {MODE, 1'b1, n};
  endfunction

  task automatic push_frame(input logic [63:0] w);
    logic [3:0] cs;
    logic [3:0] n;
    cs = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i >= 0; i--) begin
        n = w[k*32 + i*4 +: 4];
        exp_q.push_back(sym(n));
        cs ^= n;
      end
    end
`ifdef OUTPUT_STREAM_CSUM_EN
    exp_q.push_back(sym(cs));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [63:0] w);
    push_frame(w);
    bus.words = w;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.words = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // Scoreboard: every accepted symbol must match the next expected one.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL sb_extra observed=%h expected=none", bus.out_byte);
      end else begin
        chk("sb_byte", {24'd0, bus.out_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  localparam logic [63:0] W1 = {32'h9ABCDEF0, 32'h12345678};
  localparam logic [63:0] W2 = {32'h00000001, 32'h12345678};

  initial begin
    bus.start = 1'b0; bus.mode = MODE; bus.abort = 1'b0;
    bus.words = '0; bus.out_ready = 1'b1;
    #2;
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_byte", {24'd0, bus.out_byte}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: basic frame, data changed after start must not matter
    start_frame(W1);
    chk("t1_first", {24'd0, bus.out_byte}, 32'hB1);
    chk("t1_busy", {31'd0, bus.busy}, 1);
    wait_done(100, cyc);
    chk("t1_len", cyc, L);
    chk("t1_done_busy", {31'd0, bus.busy}, 0);
    chk("t1_done_byte", {24'd0, bus.out_byte}, 0);
    tick();
    chk("t1_done_pulse", {31'd0, bus.done}, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // 3: backpressure on 0xB5 for 3 cycles
    start_frame(W1);
    repeat (4) tick();
    chk("t3_at_b5", {24'd0, bus.out_byte}, 32'hB5);
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("t3_hold", {24'd0, bus.out_byte}, 32'hB5);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_next", {24'd0, bus.out_byte}, 32'hB6);
    wait_done(100, cyc);
    chk("t3_len", cyc + 8, L + 3);
    tick();
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: start while busy is ignored, abort on 0xBA
    start_frame(W1);
    repeat (2) tick();
    chk("t4_at_b3", {24'd0, bus.out_byte}, 32'hB3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t4_ignored", {24'd0, bus.out_byte}, 32'hB4);
    repeat (6) tick();
    chk("t4_at_ba", {24'd0, bus.out_byte}, 32'hBA);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    exp_q.delete();
    chk("t4_abort_valid", {31'd0, bus.out_valid}, 0);
    chk("t4_abort_byte", {24'd0, bus.out_byte}, 0);
    chk("t4_abort_done", {31'd0, bus.done}, 0);
    tick();
    chk("t4_no_done", {31'd0, bus.done}, 0);
    chk("t4_idle", {31'd0, bus.busy}, 0);
    start_frame(W1);
    chk("t4_restart", {24'd0, bus.out_byte}, 32'hB1);
    wait_done(100, cyc);
    chk("t4_len", cyc, L);
    tick();

    // 5: back-to-back with start held; second frame also checks the trailer of W2
    push_frame(W1);
    bus.words = W1;
    bus.start = 1'b1;
    tick();
    chk("t5_first", {24'd0, bus.out_byte}, 32'hB1);
    wait_done(100, cyc);
    chk("t5_len1", cyc, L);
    push_frame(W2);
    bus.words = W2;
    tick();
    bus.start = 1'b0;
    chk("t5_b2b_valid", {31'd0, bus.out_valid}, 1);
    chk("t5_b2b_byte", {24'd0, bus.out_byte}, 32'hB1);
    wait_done(100, cyc);
    chk("t5_len2", cyc, L);
    tick();
    chk("t5_sb_empty", exp_q.size(), 0);

    // 6: asynchronous reset mid-frame at 0xBC
    start_frame(W1);
    repeat (11) tick();
    chk("t6_at_bc", {24'd0, bus.out_byte}, 32'hBC);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_valid", {31'd0, bus.out_valid}, 0);
    chk("t6_byte", {24'd0, bus.out_byte}, 0);
    chk("t6_busy", {31'd0, bus.busy}, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t6_stay_idle", {31'd0, bus.busy}, 0);
    start_frame(W2);
    wait_done(100, cyc);
    chk("t6_len", cyc, L);
    tick();
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
